// File: rtl/reg_bus_arbiter_if.sv
// Signal bundle between two requesting masters, reg_bus_arbiter and the register slave.
// Lock inputs are present only when REG_BUS_ARBITER_LOCK_EN is defined.
`timescale 1ns/1ps
interface reg_bus_arbiter_if;
`ifdef REG_BUS_ARBITER_LOCK_EN
    logic        i_m0_lock;
    logic        i_m1_lock;
`endif
    logic        i_m0_req;
    logic        i_m0_we;
    logic [31:0] i_m0_addr;
    logic [7:0]  i_m0_be;
    logic [63:0] i_m0_wdata;
    logic        o_m0_gnt;
    logic        o_m0_rvalid;
    logic [63:0] o_m0_rdata;
    logic        i_m1_req;
    logic        i_m1_we;
    logic [31:0] i_m1_addr;
    logic [7:0]  i_m1_be;
    logic [63:0] i_m1_wdata;
    logic        o_m1_gnt;
    logic        o_m1_rvalid;
    logic [63:0] o_m1_rdata;
    logic        o_reg_req;
    logic        o_reg_we;
    logic [31:0] o_reg_addr;
    logic [7:0]  o_reg_be;
    logic [63:0] o_reg_wdata;
    logic [63:0] i_reg_rdata;

    // 'master' is the arbiter's own view; 'slave' is the view of everything around it.
    modport master (
`ifdef REG_BUS_ARBITER_LOCK_EN
        input  i_m0_lock, i_m1_lock,
`endif
        input  i_m0_req, i_m0_we, i_m0_addr, i_m0_be, i_m0_wdata,
        input  i_m1_req, i_m1_we, i_m1_addr, i_m1_be, i_m1_wdata,
        input  i_reg_rdata,
        output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        output o_reg_req, o_reg_we, o_reg_addr, o_reg_be, o_reg_wdata
    );

    modport slave (
`ifdef REG_BUS_ARBITER_LOCK_EN
        output i_m0_lock, i_m1_lock,
`endif
        output i_m0_req, i_m0_we, i_m0_addr, i_m0_be, i_m0_wdata,
        output i_m1_req, i_m1_we, i_m1_addr, i_m1_be, i_m1_wdata,
        output i_reg_rdata,
        input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        input  o_reg_req, o_reg_we, o_reg_addr, o_reg_be, o_reg_wdata
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter onto a register bus: accept -> issue -> respond pipeline.
// Define REG_BUS_ARBITER_LOCK_EN to enable bounded bus locking (up to LOCK_MAX grants).
`timescale 1ns/1ps
module reg_bus_arbiter #(
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_bus_arbiter_if.master bus
);

    if (LOCK_MAX < 2 || LOCK_MAX > 255) begin : g_lock_max_check
        $error("reg_bus_arbiter: LOCK_MAX must be within 2..255");
    end

    logic [1:0]  req;
    logic        last_reg;
    logic        hold;
    logic        sel;
    logic        accept;
    logic [1:0]  gnt;

    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_be;
    logic [63:0] cmd_wdata;

    logic        reg_req_reg;
    logic        issue_tag_reg;
    logic        reg_we_reg;
    logic [31:0] reg_addr_reg;
    logic [7:0]  reg_be_reg;
    logic [63:0] reg_wdata_reg;
    logic [1:0]  rvalid_reg;

    assign req = {bus.i_m1_req, bus.i_m0_req};

`ifdef REG_BUS_ARBITER_LOCK_EN
    localparam logic [7:0] CNT_MAX = 8'(LOCK_MAX);

    logic [1:0] lock;
    logic [7:0] lock_cnt_reg;
    logic [7:0] lock_cnt_next;

    assign lock = {bus.i_m1_lock, bus.i_m0_lock};
    // The previous owner keeps the bus under contention until it has used its budget.
    assign hold = lock[last_reg] && (lock_cnt_reg < CNT_MAX);

    always_comb begin
        lock_cnt_next = lock_cnt_reg;
        if (accept) begin
            if (!lock[sel])
                lock_cnt_next = 8'd0;
            else if (sel != last_reg)
                lock_cnt_next = 8'd1;
            else if (lock_cnt_reg != CNT_MAX)
                lock_cnt_next = lock_cnt_reg + 8'd1;
        end else if (!lock[last_reg]) begin
            lock_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock_cnt_reg <= 8'd0;
        else
            lock_cnt_reg <= lock_cnt_next;
    end
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        sel = req[1];
        if (req == 2'b11)
            sel = hold ? last_reg : ~last_reg;
    end

    // Grants are withheld while reset is asserted even if masters are requesting.
    assign accept = rst_n && (req != 2'b00);
    assign gnt    = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

    assign cmd_we    = sel ? bus.i_m1_we    : bus.i_m0_we;
    assign cmd_addr  = sel ? bus.i_m1_addr  : bus.i_m0_addr;
    assign cmd_be    = sel ? bus.i_m1_be    : bus.i_m0_be;
    assign cmd_wdata = sel ? bus.i_m1_wdata : bus.i_m0_wdata;

    // last_reg resets to m1 so that m0 wins the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg      <= 1'b1;
            reg_req_reg   <= 1'b0;
            issue_tag_reg <= 1'b0;
            reg_we_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            reg_be_reg    <= '0;
            reg_wdata_reg <= '0;
            rvalid_reg    <= 2'b00;
        end else begin
            reg_req_reg <= accept;
            if (accept) begin
                last_reg      <= sel;
                issue_tag_reg <= sel;
                reg_we_reg    <= cmd_we;
                reg_addr_reg  <= cmd_addr;
                reg_be_reg    <= cmd_be;
                reg_wdata_reg <= cmd_wdata;
            end
            rvalid_reg <= reg_req_reg ? (issue_tag_reg ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign bus.o_m0_gnt    = gnt[0];
    assign bus.o_m1_gnt    = gnt[1];
    assign bus.o_m0_rvalid = rvalid_reg[0];
    assign bus.o_m1_rvalid = rvalid_reg[1];
    // Slave read data arrives in the respond cycle, so it is forwarded straight through.
    assign bus.o_m0_rdata  = bus.i_reg_rdata;
    assign bus.o_m1_rdata  = bus.i_reg_rdata;
    assign bus.o_reg_req   = reg_req_reg;
    assign bus.o_reg_we    = reg_we_reg;
    assign bus.o_reg_addr  = reg_addr_reg;
    assign bus.o_reg_be    = reg_be_reg;
    assign bus.o_reg_wdata = reg_wdata_reg;

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16: maximum consecutive locked grants to one master (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have, for each master m in {m0,m1}: i_<m>_req in 1, i_<m>_we in 1, i_<m>_addr in 32, i_<m>_be in 8, i_<m>_wdata in 64 (command); o_<m>_gnt out 1 (command accepted); o_<m>_rvalid out 1 (completion); o_<m>_rdata out 64 (read data).
REQ-005 SHALL have slave ports o_reg_req out 1, o_reg_we out 1, o_reg_addr out 32, o_reg_be out 8, o_reg_wdata out 64, i_reg_rdata in 64 (rdata valid exactly one cycle after o_reg_req).

Function
REQ-006 SHALL be a 3-stage pipeline: accept (cycle N, o_<m>_gnt=1), issue (N+1, o_reg_req=1 with registered command), respond (N+2, o_<m>_rvalid=1).
REQ-007 SHALL accept at most one command per cycle; o_m0_gnt and o_m1_gnt never both 1.
REQ-008 SHALL assert o_<m>_gnt combinationally only in a cycle where i_<m>_req=1; master holds command stable until gnt, may present next command the following cycle.
REQ-009 SHALL sustain one transaction per cycle (back-to-back gnt) when requests are continuous.
REQ-010 SHALL arbitrate round-robin: single requester wins; both requesting -> master not granted last wins.
REQ-011 SHALL update last-granted pointer only on a grant; no grant -> pointer unchanged.
REQ-012 SHALL drive o_reg_req=0 in issue cycles with no accepted command; o_reg_we/addr/be/wdata hold last issued values.
REQ-013 SHALL tag each issued command with its master id and route the completion only to that master.
REQ-014 SHALL drive o_<m>_rdata = i_reg_rdata in the respond cycle for reads; value unspecified when o_<m>_rvalid=0 or for writes.
REQ-015 SHALL issue rvalid for writes too (write completion), same N+2 latency.
REQ-016 SHALL have no backpressure on responses; masters always accept rvalid.
REQ-017 SHALL pass addr/be/wdata unmodified (no width conversion, no decode).

Reset
REQ-018 SHALL on rst_n=0 immediately clear o_reg_req, all gnt, all rvalid, pipeline valid/tag bits, lock counter; o_reg_we/addr/be/wdata=0.
REQ-019 SHALL set pointer so m0 wins the first contended arbitration after reset.
REQ-020 SHALL drop in-flight commands/responses on reset mid-operation; no rvalid for them after rst_n rises.
REQ-021 SHALL accept commands in the first clock edge after rst_n deasserts.

Configuration
REQ-022 SHALL, when REG_BUS_ARBITER_LOCK_EN is defined, add inputs i_m0_lock, i_m1_lock (1 bit); a granted master with req&lock keeps winning contention for up to LOCK_MAX consecutive grants, then one grant is forced to the other requester; counter clears when lock drops or grant switches.
REQ-023 SHALL, when REG_BUS_ARBITER_LOCK_EN is undefined, omit lock ports and counter; pure round-robin per REQ-010.

Verification
REQ-024 Bench SHALL cover: m0 read addr 0x10, i_reg_rdata=0x0123456789ABCDEF -> gnt cycle N, o_reg_req N+1, o_m0_rvalid N+2 with that data; o_m1_rvalid stays 0.
REQ-025 Bench SHALL cover: m0 and m1 requesting continuously 8 cycles after reset -> grants m0,m1,m0,m1,..., 8 o_reg_req cycles back-to-back, completions routed per tag.
REQ-026 Bench SHALL cover: m1 write be=0x0F, wdata=0xDEADBEEF -> o_reg_we=1, o_reg_be=0x0F at N+1, o_m1_rvalid at N+2.
REQ-027 Bench SHALL cover: rst_n low for 1 cycle while 2 commands in flight -> no rvalid afterwards, all outputs 0, next contended grant to m0.
REQ-028 Bench SHALL cover (LOCK_EN, LOCK_MAX=4): m0 req+lock and m1 req continuous -> grant pattern m0,m0,m0,m0,m1,m0,...; without macro -> alternating.
